// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin sharing of one external adder
// Grants one requester per cycle, drives the adder and queues {id, sum} in a 2-deep FWFT FIFO.
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 12,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [2*WIDTH-1:0]       add_in,
  input  logic [WIDTH:0]           add_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH:0]           rsp_sum,
  output logic [CNT_W-1:0]         ops_done
);

  logic [1:0]       count_q, count_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id0_q, id0_d, id1_q, id1_d;
  logic [WIDTH:0]   sum0_q, sum0_d, sum1_q, sum1_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  logic             pop, accept, grant_found, grant_valid, push;
  logic [ID_W-1:0]  grant_idx;
  logic [WIDTH-1:0] sel_a, sel_b;
  int               idx;

  assign pop       = (count_q != 2'd0) && rsp_ready;
  // A pop in the same cycle frees the slot a full FIFO would otherwise block.
  assign accept    = (count_q < 2'd2) || pop;
  assign rsp_valid = (count_q != 2'd0);
  assign rsp_id    = id0_q;
  assign rsp_sum   = sum0_q;
  assign ops_done  = ops_done_q;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_ptr_q) + off) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  assign grant_valid = grant_found && accept && !rst;
  assign push        = grant_valid;
  assign req_ready   = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    add_in = '0;
    if (grant_valid) begin
      sel_a = req_a[int'(grant_idx)*WIDTH +: WIDTH];
      sel_b = req_b[int'(grant_idx)*WIDTH +: WIDTH];
      for (int k = 0; k < WIDTH; k++) begin
        add_in[2*k]   = sel_a[k];
        add_in[2*k+1] = sel_b[k];
      end
    end
  end

  always_comb begin
    count_d    = count_q;
    rr_ptr_d   = rr_ptr_q;
    id0_d      = id0_q;
    id1_d      = id1_q;
    sum0_d     = sum0_q;
    sum1_d     = sum1_q;
    ops_done_d = ops_done_q;

    if (push) begin
      rr_ptr_d = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end

    if (pop) begin
      id0_d  = id1_q;
      sum0_d = sum1_q;
      if (ops_done_q != '1) begin
        ops_done_d = ops_done_q + 1'b1;
      end
    end

    // New entry lands in whichever slot is the tail after any pop this cycle.
    if (push) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        id0_d  = grant_idx;
        sum0_d = add_out;
      end else begin
        id1_d  = grant_idx;
        sum1_d = add_out;
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      rr_ptr_q   <= '0;
      id0_q      <= '0;
      id1_q      <= '0;
      sum0_q     <= '0;
      sum1_q     <= '0;
      ops_done_q <= '0;
    end else begin
      count_q    <= count_d;
      rr_ptr_q   <= rr_ptr_d;
      id0_q      <= id0_d;
      id1_q      <= id1_d;
      sum0_q     <= sum0_d;
      sum1_q     <= sum1_d;
      ops_done_q <= ops_done_d;
    end
  end

endmodule
